// File: rtl/wb_monitor_master_if.sv
// Wishbone initiator/responder signal bundle used by wb_monitor_master.
interface wb_monitor_master_if;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_monitor_master.sv
// Wishbone master that probes a monitor, programs channel/bounds, then
// polls the failure register until a violation, abort or bus timeout.
module wb_monitor_master #(
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [4:0]          cfg_channel,
  input  logic [31:0]         cfg_lower,
  input  logic [31:0]         cfg_upper,
  wb_monitor_master_if.master wb,
  output logic                busy,
  output logic                monitoring,
  output logic                absent,
  output logic                bus_error,
  output logic                fail_valid,
  output logic [30:0]         fail_time
);

  typedef enum logic [3:0] {
    IDLE, PROBE, WR_CHAN, WR_LOW, WR_UP, CTL_SET, CTL_CLR, WAIT, POLL, ERROR
  } state_e;

  localparam logic [19:0] PI_M1 = 20'(POLL_INTERVAL - 1);
  localparam logic [15:0] AT_M1 = 16'(ACK_TIMEOUT - 1);

  state_e      state_q;
  logic        cyc_q, stb_q, we_q;
  logic [7:0]  adr_q;
  logic [31:0] dat_q;
  logic [15:0] tcnt_q;
  logic [19:0] wcnt_q;
  logic        pend_q;
  logic [4:0]  chan_q;
  logic [31:0] lo_q, up_q;
  logic        busy_q, mon_q, absent_q, berr_q, fv_q;
  logic [30:0] ft_q;

  logic [7:0]  req_adr;
  logic        req_we;
  logic [31:0] req_dat;

  always_comb begin
    req_adr = 8'h00;
    req_we  = 1'b0;
    req_dat = 32'h0;
    case (state_q)
      WR_CHAN: begin req_adr = 8'h08; req_we = 1'b1; req_dat = {27'b0, chan_q}; end
      WR_LOW:  begin req_adr = 8'h0C; req_we = 1'b1; req_dat = lo_q; end
      WR_UP:   begin req_adr = 8'h10; req_we = 1'b1; req_dat = up_q; end
      CTL_SET: begin req_adr = 8'h04; req_we = 1'b1; req_dat = 32'd1; end
      CTL_CLR: begin req_adr = 8'h04; req_we = 1'b1; req_dat = 32'd0; end
      POLL:    req_adr = 8'h14;
      default: req_adr = 8'h00;
    endcase
  end

  // Every state change goes through here so busy/monitoring stay registered
  // alongside the state and any recorded abort is consumed.
  task automatic go(input state_e s);
    state_q <= s;
    busy_q  <= !(s == IDLE || s == ERROR);
    mon_q   <= (s == WAIT || s == POLL);
    pend_q  <= 1'b0;
  endtask

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      tcnt_q   <= '0;
      wcnt_q   <= '0;
      pend_q   <= 1'b0;
      chan_q   <= '0;
      lo_q     <= '0;
      up_q     <= '0;
      busy_q   <= 1'b0;
      mon_q    <= 1'b0;
      absent_q <= 1'b0;
      berr_q   <= 1'b0;
      fv_q     <= 1'b0;
      ft_q     <= '0;
    end else begin
      case (state_q)
        IDLE, ERROR: if (start) begin
          chan_q   <= cfg_channel;
          lo_q     <= cfg_lower;
          up_q     <= cfg_upper;
          absent_q <= 1'b0;
          berr_q   <= 1'b0;
          fv_q     <= 1'b0;
          ft_q     <= '0;
          go(PROBE);
        end
        WAIT: begin
          if (abort)                 go(IDLE);
          else if (wcnt_q == PI_M1)  go(POLL);
          else                       wcnt_q <= wcnt_q + 20'd1;
        end
        default: begin
          if (!cyc_q) begin
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            adr_q  <= req_adr;
            we_q   <= req_we;
            dat_q  <= req_dat;
            tcnt_q <= '0;
            if (abort) pend_q <= 1'b1;
          end else if (wb.wb_ack_i) begin
            // Ack wins over a coincident timeout; abort only acts at completion.
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (abort || pend_q) go(IDLE);
            else begin
              case (state_q)
                PROBE: if (wb.wb_dat_i == 32'd1) go(WR_CHAN);
                       else begin absent_q <= 1'b1; go(IDLE); end
                WR_CHAN: go(WR_LOW);
                WR_LOW:  go(WR_UP);
                WR_UP:   go(CTL_SET);
                CTL_SET: go(CTL_CLR);
                CTL_CLR: begin wcnt_q <= '0; go(WAIT); end
                POLL: if (wb.wb_dat_i[31]) begin
                  ft_q <= wb.wb_dat_i[30:0];
                  fv_q <= 1'b1;
                  go(IDLE);
                end else begin
                  wcnt_q <= '0;
                  go(WAIT);
                end
                default: go(IDLE);
              endcase
            end
          end else if (tcnt_q == AT_M1) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            berr_q <= 1'b1;
            go(ERROR);
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
            if (abort) pend_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign busy        = busy_q;
  assign monitoring  = mon_q;
  assign absent      = absent_q;
  assign bus_error   = berr_q;
  assign fail_valid  = fv_q;
  assign fail_time   = ft_q;

endmodule

// File: tb/tb_wb_monitor_master.sv
// Directed bench for wb_monitor_master with a programmable Wishbone responder.
module tb_wb_monitor_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [4:0]  cfg_channel = '0;
  logic [31:0] cfg_lower = '0, cfg_upper = '0;
  logic        busy, monitoring, absent, bus_error, fail_valid;
  logic [30:0] fail_time;

  wb_monitor_master_if wbif ();

  wb_monitor_master #(.POLL_INTERVAL(4), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_channel(cfg_channel), .cfg_lower(cfg_lower), .cfg_upper(cfg_upper),
    .wb(wbif), .busy(busy), .monitoring(monitoring), .absent(absent),
    .bus_error(bus_error), .fail_valid(fail_valid), .fail_time(fail_time)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0, cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // Responder: acks dly cycles after stb, optionally never acks one address.
  logic        ack_r = 1'b0;
  logic [31:0] rdat_r = '0;
  assign wbif.wb_ack_i = ack_r;
  assign wbif.wb_dat_i = rdat_r;
  int          dly = 1, rcnt = 0, hi0c = 0, hi14 = 0;
  logic        noack_en = 1'b0;
  logic [31:0] presence = 32'd1;
  logic [39:0] wlog[$];
  logic [31:0] pq[$];
  int          pt[$];

  always @(negedge clk) begin
    if (wbif.wb_cyc_o && wbif.wb_adr_o == 8'h0C) hi0c++;
    if (wbif.wb_cyc_o && wbif.wb_adr_o == 8'h14) hi14++;
    if (wbif.wb_cyc_o && wbif.wb_stb_o && !ack_r) begin
      if (!(noack_en && wbif.wb_adr_o == 8'h0C) && rcnt == dly) begin
        ack_r = 1'b1;
        rcnt = 0;
        if (wbif.wb_we_o) wlog.push_back({wbif.wb_adr_o, wbif.wb_dat_o});
        else if (wbif.wb_adr_o == 8'h00) rdat_r = presence;
        else begin
          rdat_r = (pq.size() > 0) ? pq.pop_front() : 32'h0;
          pt.push_back(cyc_n);
        end
      end else rcnt++;
    end else begin
      ack_r = 1'b0;
      rcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [39:0] exp_w[5];
    int base;
    exp_w[0] = {8'h08, 32'h2};      exp_w[1] = {8'h0C, 32'h190000};
    exp_w[2] = {8'h10, 32'h200000}; exp_w[3] = {8'h04, 32'h1};
    exp_w[4] = {8'h04, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_cyc", wbif.wb_cyc_o, 0);
    chk("rst_stb", wbif.wb_stb_o, 0);
    chk("rst_adr_dat", {wbif.wb_adr_o, wbif.wb_dat_o}, 0);
    chk("rst_flags", {busy, monitoring, absent, bus_error, fail_valid}, 0);
    chk("rst_ftime", fail_time, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", {busy, wbif.wb_cyc_o}, 0);

    // Configure sequence and polling until a violation is reported.
    cfg_channel = 5'd2; cfg_lower = 32'h190000; cfg_upper = 32'h200000;
    pq.push_back(32'h0); pq.push_back(32'h0); pq.push_back(32'h80001234);
    pulse_start();
    chk("busy_after_start", busy, 1);
    for (int n = 0; n < 200 && !monitoring; n++) @(negedge clk);
    chk("monitoring", monitoring, 1);
    chk("wlog_size", wlog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wlog.size()) chk($sformatf("write%0d", i), wlog[i], exp_w[i]);
    for (int n = 0; n < 300 && !fail_valid; n++) @(negedge clk);
    chk("fail_valid", fail_valid, 1);
    chk("fail_time", fail_time, 31'h1234);
    chk("busy_done", {busy, monitoring}, 0);
    chk("poll_count", pt.size(), 3);
    if (pt.size() >= 2) chk("poll_gap", (pt[1] - pt[0]) >= 5, 1);

    // Absent monitor: no writes, flags from the previous run cleared.
    presence = 32'd0;
    wlog.delete();
    pulse_start();
    for (int n = 0; n < 100 && busy; n++) @(negedge clk);
    chk("absent", {absent, fail_valid, busy}, 3'b100);
    chk("absent_ftime", fail_time, 0);
    chk("absent_nowrite", wlog.size(), 0);

    // Timeout on WR_LOW, then restart from ERROR.
    presence = 32'd1;
    noack_en = 1'b1;
    hi0c = 0;
    pulse_start();
    for (int n = 0; n < 200 && !bus_error; n++) @(negedge clk);
    chk("bus_error", {bus_error, busy, wbif.wb_cyc_o}, 3'b100);
    chk("timeout_len", hi0c, 8);
    noack_en = 1'b0;
    presence = 32'd0;
    pt.delete();
    pulse_start();
    chk("restart_clear", {busy, bus_error}, 2'b10);
    for (int n = 0; n < 100 && busy; n++) @(negedge clk);
    chk("restart_probe", {absent, busy}, 2'b10);

    // start+abort together: start wins; then abort while in WAIT.
    presence = 32'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_wins", busy, 1);
    for (int n = 0; n < 200 && !monitoring; n++) @(negedge clk);
    chk("start_wins_mon", monitoring, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_wait", {busy, monitoring, wbif.wb_cyc_o}, 0);

    // Abort during a stalled POLL read.
    dly = 3;
    base = hi14;
    pt.delete();
    pulse_start();
    for (int n = 0; n < 300 && !(wbif.wb_cyc_o && wbif.wb_adr_o == 8'h14); n++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int n = 0; n < 50 && busy; n++) @(negedge clk);
    chk("abort_poll_idle", {busy, monitoring, fail_valid, wbif.wb_cyc_o}, 0);
    chk("abort_poll_done", pt.size(), 1);
    chk("abort_poll_held", hi14 - base, 4);

    // Reset in the middle of CTL_SET.
    dly = 1;
    pulse_start();
    for (int n = 0; n < 200 && !(wbif.wb_cyc_o && wbif.wb_adr_o == 8'h04 && wbif.wb_dat_o == 32'd1); n++)
      @(negedge clk);
    chk("ctl_set_seen", {wbif.wb_cyc_o, wbif.wb_adr_o}, {1'b1, 8'h04});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", {wbif.wb_cyc_o, wbif.wb_stb_o, wbif.wb_we_o}, 0);
    chk("rst_mid_bus", {wbif.wb_adr_o, wbif.wb_dat_o}, 0);
    chk("rst_mid_flags", {busy, monitoring, absent, bus_error, fail_valid, fail_time}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = hi0c + hi14;
    repeat (10) @(negedge clk);
    chk("rst_stays_idle", {busy, wbif.wb_cyc_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
